// File: rtl/edge_to_level_gen_pkg.sv
// ---------------------------------------------------------------------------
// edge_gen_pkg
// Shared types for the edge-to-level generator.
//   state_t   : the four states of the level FSM (idle or dwelling, per level)
//   pending_t : one-deep queue of a request that arrived during a dwell
//   maxOf     : constant helper used to size the dwell counter
// ---------------------------------------------------------------------------
package edge_gen_pkg;

    typedef enum logic [1:0] {
        LOW_IDLE,
        HIGH_IDLE,
        LOW_HOLD,
        HIGH_HOLD
    } state_t;

    typedef struct packed {
        logic valid;
        logic level;
    } pending_t;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/edge_to_level_gen_if.sv
// ---------------------------------------------------------------------------
// edge_to_level_gen_if
// Request/level bundle of the edge-to-level generator.
//   rise_req_i / fall_req_i : one-cycle requests into the generator
//   a_o                     : generated level
//   ack_o                   : pulse in the first cycle of a new level
//   drop_o                  : pulse when a request was rejected
//   busy_o                  : dwell running or a request pending
// master drives requests (requester side), slave is the generator.
// ---------------------------------------------------------------------------
interface edge_to_level_gen_if;

    logic rise_req_i;
    logic fall_req_i;
    logic a_o;
    logic ack_o;
    logic drop_o;
    logic busy_o;

    modport master (
        output rise_req_i,
        output fall_req_i,
        input  a_o,
        input  ack_o,
        input  drop_o,
        input  busy_o
    );

    modport slave (
        input  rise_req_i,
        input  fall_req_i,
        output a_o,
        output ack_o,
        output drop_o,
        output busy_o
    );

endinterface

// File: rtl/edge_to_level_gen_dwell_counter.sv
// ---------------------------------------------------------------------------
// dwell_counter
// Down-counter timing the minimum dwell of the current level.
//   clk, reset   : clock, synchronous active-high reset (counter -> 0)
//   load_i       : load load_val_i (has priority over decrement)
//   load_val_i   : remaining cycles of the new dwell minus one
//   dec_i        : decrement by one; saturates at zero
//   zero_o       : counter currently reads zero
// ---------------------------------------------------------------------------
module dwell_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    // The counter is only ever reloaded on a toggle, and the decrement stops
    // at zero, so it can never wrap around.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/edge_to_level_gen.sv
// ---------------------------------------------------------------------------
// edge_to_level_gen
// Rebuilds a glitch-free level from single-cycle rise/fall request pulses,
// holding each level for a minimum dwell and queueing one request that
// arrives while a dwell is still running.
//   clk, reset : clock, synchronous active-high reset
//   bus.slave  : rise_req_i, fall_req_i in; a_o, ack_o, drop_o, busy_o out
// Parameters: MIN_HIGH / MIN_LOW minimum cycles per level (>= 1),
//             CNT_W width of the dwell counter.
// ---------------------------------------------------------------------------
module edge_to_level_gen
    import edge_gen_pkg::*;
#(
    parameter int MIN_HIGH = 3,
    parameter int MIN_LOW  = 2,
    parameter int CNT_W    = $clog2(maxOf(MIN_HIGH, MIN_LOW) + 1)
) (
    input  logic                clk,
    input  logic                reset,
    edge_to_level_gen_if.slave  bus
);

    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(MIN_HIGH - 1);
    localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(MIN_LOW - 1);

    state_t   state_q, state_d;
    pending_t pend_q, pend_d;
    logic     a_q, a_d;
    logic     ack_q, ack_d;
    logic     drop_q, drop_d;

    logic     targetLevel;
    logic     anyReq;
    logic     acceptReq;
    logic     inHold;
    logic     cntZero;
    logic     toggle;
    logic     setPend;
    logic     [CNT_W-1:0] cntLoadVal;

    // A request is judged against the level the output is heading to, which
    // is the queued level if one is pending. With the slot full every request
    // is rejected, so acceptance also requires an empty slot.
    always_comb begin
        targetLevel = pend_q.valid ? pend_q.level : a_q;
        anyReq      = bus.rise_req_i | bus.fall_req_i;
        acceptReq   = (bus.rise_req_i ^ bus.fall_req_i) && !pend_q.valid &&
                      (bus.rise_req_i != targetLevel);
        inHold      = (state_q == LOW_HOLD) || (state_q == HIGH_HOLD);
        // In a hold, the last dwell cycle may toggle straight away for either
        // a queued request or one arriving on that very edge.
        toggle      = inHold ? (cntZero && (pend_q.valid || acceptReq)) : acceptReq;
        setPend     = inHold && !cntZero && acceptReq;
        cntLoadVal  = a_q ? LOW_LOAD : HIGH_LOAD;
    end

    dwell_counter #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk        (clk),
        .reset      (reset),
        .load_i     (toggle),
        .load_val_i (cntLoadVal),
        .dec_i      (inHold),
        .zero_o     (cntZero)
    );

    // Next-state of the level FSM. A toggle always lands in the HOLD state of
    // the new level and clears the pending slot; a hold whose dwell expired
    // with nothing to do falls back to IDLE of the current level.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        a_d     = a_q;
        ack_d   = 1'b0;
        drop_d  = anyReq && !acceptReq;
        if (toggle) begin
            a_d          = !a_q;
            ack_d        = 1'b1;
            pend_d.valid = 1'b0;
            pend_d.level = 1'b0;
            state_d      = a_q ? LOW_HOLD : HIGH_HOLD;
        end else if (setPend) begin
            pend_d.valid = 1'b1;
            pend_d.level = bus.rise_req_i;
        end else if (inHold && cntZero) begin
            state_d = a_q ? HIGH_IDLE : LOW_IDLE;
        end
    end

    // State and registered outputs; reset drops any dwell or queued request
    // without acknowledging it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOW_IDLE;
            pend_q  <= '0;
            a_q     <= 1'b0;
            ack_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            a_q     <= a_d;
            ack_q   <= ack_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.a_o    = a_q;
    assign bus.ack_o  = ack_q;
    assign bus.drop_o = drop_q;
    assign bus.busy_o = inHold || pend_q.valid;

endmodule

// File: tb/tb_edge_to_level_gen.sv
// ---------------------------------------------------------------------------
// tb_edge_to_level_gen
// Directed bench for edge_to_level_gen with MIN_HIGH=3, MIN_LOW=2. Each
// vector row drives one cycle of inputs and carries the hand-computed outputs
// expected in the following cycle; a monitor pops them and compares.
// ---------------------------------------------------------------------------
module tb_edge_to_level_gen;

    logic clk;
    logic reset;

    edge_to_level_gen_if bus();

    edge_to_level_gen #(
        .MIN_HIGH (3),
        .MIN_LOW  (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row layout: {reset, rise, fall, expA, expAck, expDrop, expBusy}
    localparam int NVEC = 33;
    logic [6:0] vecs [NVEC] = '{
        7'b100_0000,  //  1 reset
        7'b110_0000,  //  2 reset, rise ignored
        7'b000_0000,  //  3 low idle
        7'b010_1101,  //  4 rise -> high, ack
        7'b000_1001,  //  5 high hold
        7'b000_1001,  //  6 high hold
        7'b000_1000,  //  7 high idle
        7'b010_1010,  //  8 redundant rise -> drop
        7'b001_0101,  //  9 fall from idle -> low, ack
        7'b000_0001,  // 10 low hold
        7'b010_1101,  // 11 rise on last dwell cycle -> toggles at once
        7'b010_1011,  // 12 redundant rise in high hold -> drop
        7'b001_1001,  // 13 fall queued
        7'b000_0101,  // 14 queued fall executes after 3 high cycles
        7'b000_0001,  // 15 low hold
        7'b000_0000,  // 16 low idle
        7'b011_0010,  // 17 rise+fall together -> drop, no change
        7'b001_0010,  // 18 redundant fall -> drop
        7'b010_1101,  // 19 rise -> high
        7'b001_1001,  // 20 fall queued
        7'b010_1011,  // 21 rise with slot full -> drop
        7'b000_0101,  // 22 queued fall executes
        7'b010_0001,  // 23 rise queued in low hold
        7'b000_1101,  // 24 queued rise executes after 2 low cycles
        7'b001_1001,  // 25 fall queued
        7'b100_0000,  // 26 reset discards dwell and queued fall
        7'b010_1101,  // 27 rise -> high
        7'b000_1001,  // 28 high hold
        7'b011_1011,  // 29 both in hold -> drop, dwell continues
        7'b000_1000,  // 30 high idle
        7'b001_0101,  // 31 fall -> low
        7'b110_0000,  // 32 reset with rise ignored
        7'b000_0000   // 33 low idle
    };

    logic [3:0] expQ [$];
    int compared   = 0;
    int mismatched = 0;

    task automatic checkOutput(input string name, input int row, input logic actual, input logic expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s row %0d: got %b, expected %b", name, row, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] v);
        @(negedge clk);
        reset          = v[6];
        bus.rise_req_i = v[5];
        bus.fall_req_i = v[4];
        expQ.push_back(v[3:0]);
    endtask

    // Monitor: one expected entry is consumed per cycle after the edge that
    // the corresponding row was sampled on.
    initial begin : monitor
        int row;
        logic [3:0] exp;
        row = 0;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                exp = expQ.pop_front();
                row++;
                checkOutput("a_o",    row, bus.a_o,    exp[3]);
                checkOutput("ack_o",  row, bus.ack_o,  exp[2]);
                checkOutput("drop_o", row, bus.drop_o, exp[1]);
                checkOutput("busy_o", row, bus.busy_o, exp[0]);
            end
        end
    end

    initial begin : driver
        reset          = 1'b1;
        bus.rise_req_i = 1'b0;
        bus.fall_req_i = 1'b0;
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
        end
        @(negedge clk);
        reset          = 1'b0;
        bus.rise_req_i = 1'b0;
        bus.fall_req_i = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL queue_drained: %0d entries left, expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/edge_to_level_gen.md
Name: edge_to_level_gen

Overview:
- Reconstructs a glitch-free level signal `a_o` from single-cycle rise and fall request pulses. It is the generating counterpart of the rising/falling edge detector.
- Enforces a minimum dwell time at each level and queues one request that arrives during a dwell.
- Sits on the transmit side of any level/edge link. Its `a_o` feeds the edge detector's `a_i` directly in loopback benches.

Parameters:
- MIN_HIGH, default 3: minimum cycles `a_o` stays 1 after rising. Legal range is 1 or more.
- MIN_LOW, default 2: minimum cycles `a_o` stays 0 after falling. Legal range is 1 or more.
- CNT_W, default $clog2(max(MIN_HIGH,MIN_LOW)+1): width of the dwell counter.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- rise_req_i  input  1  one-cycle request to drive `a_o` high.
- fall_req_i  input  1  one-cycle request to drive `a_o` low.
- a_o  output  1  generated level, registered.
- ack_o  output  1  one-cycle pulse, registered; high in the first cycle `a_o` shows a new level.
- drop_o  output  1  one-cycle pulse, registered; a request was rejected.
- busy_o  output  1  high while a dwell is running or a request is pending.

Behaviour:
- Reset, synchronous and active-high:
  - At a posedge with `reset`=1: `a_o`=0, `ack_o`=0, `drop_o`=0, `busy_o`=0, state LOW_IDLE, pending cleared, counter 0.
  - Reset applied mid-dwell or with a request pending discards everything. No ack is issued for the lost request.
  - Requests are ignored while `reset`=1.
- States: LOW_IDLE, HIGH_IDLE, LOW_HOLD, HIGH_HOLD. Plus a one-deep pending register (valid bit and target level).
- Target level: the pending level if pending is valid, else the current `a_o`.
- Accept rules, evaluated at each posedge:
  - Exactly one request is asserted and it differs from the target level → accepted.
  - Both `rise_req_i` and `fall_req_i` asserted → both rejected; `drop_o`=1 next cycle; no state change.
  - Request equals the target level (redundant) → rejected; `drop_o`=1.
  - Request arrives while pending is already valid → rejected; `drop_o`=1.
- Toggle from IDLE:
  - An accepted request toggles `a_o` at the same edge, so the new level is visible the cycle after the request. Latency is 1.
  - `ack_o`=1 for that cycle.
  - Enter the HOLD state of the new level, with counter = MIN_x−1.
- HOLD behaviour:
  - Counter decrements each cycle.
  - An accepted request sets the pending register.
  - At an edge where counter==0: if pending is valid, or an accepted request arrives that same cycle, toggle `a_o`, pulse `ack_o`, clear pending, and reload the counter for the new level. Otherwise go to the IDLE state of the current level.
- Dwell guarantee: `a_o` holds each level for at least MIN_x cycles. With MIN_x=1, back-to-back toggles on consecutive cycles are legal.
- `busy_o`: combinational from registers; = (state is a HOLD state) OR pending valid.
- Sequencing constraints:
  - `ack_o` and `drop_o` never assert in the same cycle for the same request.
  - At most one toggle per cycle.
  - Counter never wraps, because it is reloaded only on a toggle.

Decomposition:
- Package `edge_gen_pkg`:
  - typedef enum logic [1:0] state_t {LOW_IDLE, HIGH_IDLE, LOW_HOLD, HIGH_HOLD}.
  - struct pending_t {logic valid; logic level;}.
- Sub-module `dwell_counter`: load value, load strobe, decrement enable, zero flag; width CNT_W.
- Top-level holds the FSM, pending register, accept logic and output registers.

Test Plan (MIN_HIGH=3, MIN_LOW=2):
- Reset held 2 cycles, no requests → `a_o`=0, `ack_o`=0, `drop_o`=0, `busy_o`=0 throughout.
- `rise_req_i` in cycle 2 → `a_o`=1 from cycle 3; `ack_o`=1 in cycle 3 only; `busy_o`=1 in cycles 3–5; HIGH_IDLE from cycle 6.
- Rise in cycle 2, fall in cycle 3 → fall is pending; `a_o`=1 in cycles 3–5, `a_o`=0 from cycle 6; `ack_o` pulses in cycles 3 and 6; `busy_o`=1 in cycles 3–7.
- Rise and fall asserted together in cycle 4 with `a_o`=0 idle → `drop_o`=1 in cycle 5; `a_o` stays 0; no `ack_o`.
- Rise while high-idle, then rise-fall-rise during HIGH_HOLD → redundant rise gives `drop_o`; the second rise (slot full) gives `drop_o`; only the fall executes, after 3 high cycles.
- Reset in cycle 4 during HIGH_HOLD with a fall pending → cycle 5 shows `a_o`=0, `busy_o`=0, no `ack_o`; a new rise in cycle 6 gives `a_o`=1 in cycle 7.
